// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   BYTE_W      : width of one UART payload byte
//   arb_state_e : sequencer states (2-bit encoding)
//   ptr_width() : bits needed to index NUM_REQ requesters (minimum 1)
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } arb_state_e;

  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority selector.
// Picks the first asserted request at an index >= ptr, wrapping modulo NUM_REQ.
//   req : request vector
//   ptr : highest-priority index for this decision (must be < NUM_REQ)
//   gnt : one-hot winner (0 when nothing requested)
//   idx : binary index of the winner
//   vld : at least one request present
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               vld
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  logic [PTR_W:0]   cand;
  logic [PTR_W-1:0] cand_idx;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    vld      = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W + 1)'(i);
      if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
        cand = cand - (PTR_W + 1)'(NUM_REQ);
      end
      cand_idx = cand[PTR_W-1:0];
      if (!vld && req[cand_idx]) begin
        vld           = 1'b1;
        idx           = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ
// requesters. The winner's byte and parity mode are latched at the grant edge,
// the transmitter is driven through its send/busy handshake, and a one-cycle
// ack returns to the winner when the frame ends (or when busy never rose).
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester level request, held until ack
//   req_din      : flattened bytes, requester i at [8i+7:8i]
//   req_odd      : per-requester parity mode (1 = odd)
//   ack          : one-cycle pulse to the served requester
//   grant        : one-hot owner of the current transfer, 0 when idle
//   tx_send/din/odd : to transmitter
//   tx_busy      : from transmitter
//   timeout_err  : pulses with ack when tx_busy never rose after tx_send
//   active       : high in every state except IDLE
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64,
  parameter int GAP_CLOCKS   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_din,
  input  logic [NUM_REQ-1:0]        req_odd,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_send,
  output logic [BYTE_W-1:0]         tx_din,
  output logic                      tx_odd,
  input  logic                      tx_busy,
  output logic                      timeout_err,
  output logic                      active
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam int GAP_W = $clog2(GAP_CLOCKS + 1);

  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLOCKS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [BYTE_W-1:0]   tx_din_q, tx_din_d;
  logic                tx_odd_q, tx_odd_d;
  logic                tx_send_q, tx_send_d;
  logic                timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_vld;
  logic [PTR_W-1:0]    ptr_after_win;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Priority moves to the requester just after the one being served.
  assign ptr_after_win = (win_q == PTR_LAST) ? '0 : win_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_d         = win_q;
    grant_d       = grant_q;
    ack_d         = '0;
    tx_din_d      = tx_din_q;
    tx_odd_d      = tx_odd_q;
    tx_send_d     = tx_send_q;
    timeout_err_d = 1'b0;
    to_cnt_d      = to_cnt_q;
    gap_cnt_d     = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Holding off while tx_busy is high also protects a frame that was
        // still on the line when reset hit.
        if (pick_vld && !tx_busy) begin
          grant_d   = pick_gnt;
          win_d     = pick_idx;
          tx_din_d  = req_din[int'(pick_idx)*BYTE_W +: BYTE_W];
          tx_odd_d  = req_odd[pick_idx];
          tx_send_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = ST_SEND;
        end
      end

      ST_SEND: begin
        if (tx_busy) begin
          tx_send_d = 1'b0;
          state_d   = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          tx_send_d     = 1'b0;
          ack_d         = grant_q;
          timeout_err_d = 1'b1;
          ptr_d         = ptr_after_win;
          grant_d       = '0;
          gap_cnt_d     = '0;
          state_d       = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          ack_d     = grant_q;
          ptr_d     = ptr_after_win;
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      grant_q       <= '0;
      ack_q         <= '0;
      tx_din_q      <= '0;
      tx_odd_q      <= 1'b0;
      tx_send_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      grant_q       <= grant_d;
      ack_q         <= ack_d;
      tx_din_q      <= tx_din_d;
      tx_odd_q      <= tx_odd_d;
      tx_send_q     <= tx_send_d;
      timeout_err_q <= timeout_err_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign tx_send     = tx_send_q;
  assign tx_din      = tx_din_q;
  assign tx_odd      = tx_odd_q;
  assign timeout_err = timeout_err_q;
  assign active      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural transmitter: it accepts
// tx_send when idle, records {odd, byte} as the frame on the line, and holds
// busy for FRAME clocks. busy_mode 1 ties busy low, 2 forces it high.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int BT    = 64;
  localparam int GAPC  = 16;
  localparam int FRAME = 40;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_din = '0;
  logic [3:0]  req_odd = '0;
  logic [3:0]  ack, grant;
  logic        tx_send, tx_odd, tx_busy, timeout_err, active;
  logic [7:0]  tx_din;

  uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(BT), .GAP_CLOCKS(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_din(req_din), .req_odd(req_odd),
    .ack(ack), .grant(grant), .tx_send(tx_send), .tx_din(tx_din), .tx_odd(tx_odd),
    .tx_busy(tx_busy), .timeout_err(timeout_err), .active(active)
  );

  always #5 clk = ~clk;

  // transmitter model
  int         busy_mode = 0;
  logic       model_busy = 1'b0;
  int         busy_left = 0;
  logic [8:0] frame_mem [0:255];
  int         frame_wr = 0;
  int         frame_rd = 0;

  assign tx_busy = (busy_mode == 1) ? 1'b0 : (busy_mode == 2) ? 1'b1 : model_busy;

  always @(posedge clk) begin
    if (model_busy) begin
      if (busy_left <= 1) model_busy <= 1'b0;
      busy_left <= busy_left - 1;
    end else if (busy_mode == 0 && tx_send) begin
      model_busy <= 1'b1;
      busy_left  <= FRAME;
      frame_mem[frame_wr[7:0]] <= {tx_odd, tx_din};
      frame_wr   <= frame_wr + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_frame(input string name, input logic [8:0] exp);
    if (frame_rd >= frame_wr) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no frame on the line, want 0x%0h", name, exp);
    end else begin
      chk(name, 32'(frame_mem[frame_rd[7:0]]), 32'(exp));
      frame_rd++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || tx_busy) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    if (active || tx_busy) chk("idle_wait", 32'(active), 32'd0);
  endtask

  // Round-robin rule: first set request at index >= p, wrapping.
  function automatic int rr_ref(input int p, input logic [3:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Wait for the ack of the current transfer, checking that grant/data hold.
  task automatic finish_xfer(input logic [3:0] eg, input logic [8:0] ef);
    int n = 0;
    int bad = 0;
    while (ack == 4'd0 && n < BOUND) begin
      if (grant !== eg || tx_din !== ef[7:0] || tx_odd !== ef[8]) bad++;
      @(negedge clk);
      n++;
    end
    chk("hold_stable", bad, 0);
    chk("ack", ack, eg);
    chk("ack_terr", timeout_err, 0);
    chk("ack_grant_clr", grant, 0);
    chk_frame("frame", ef);
    req = req & ~eg;
    @(negedge clk);
    chk("ack_pulse", ack, 0);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  odd;
    bit          drop;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_byte;
    logic        exp_odd;
  } vec_t;

  task automatic do_xfer(input vec_t v);
    wait_idle();
    req_din = v.din;
    req_odd = v.odd;
    req     = v.req;
    @(negedge clk);
    chk("grant", grant, v.exp_grant);
    chk("tx_send", tx_send, 1);
    chk("tx_din", tx_din, v.exp_byte);
    chk("tx_odd", tx_odd, v.exp_odd);
    chk("active", active, 1);
    req_din = ~v.din;
    if (v.drop) req = '0;
    finish_xfer(v.exp_grant, {v.exp_odd, v.exp_byte});
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];
  vec_t vw;

  initial begin
    vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 1'b0, 4'b0100, 8'hA5, 1'b1};
    vecs[1] = '{4'b1001, 32'h5A0000C3, 4'b0001, 1'b0, 4'b1000, 8'h5A, 1'b0};
    vecs[2] = '{4'b1001, 32'h5A0000C3, 4'b0001, 1'b0, 4'b0001, 8'hC3, 1'b1};
    vecs[3] = '{4'b0001, 32'h0000007E, 4'b0000, 1'b1, 4'b0001, 8'h7E, 1'b0};
    vecs[4] = '{4'b1110, 32'h44332211, 4'b1010, 1'b0, 4'b0010, 8'h22, 1'b1};
    vecs[5] = '{4'b0011, 32'h44332211, 4'b0001, 1'b0, 4'b0001, 8'h11, 1'b1};
    vecs[6] = '{4'b1100, 32'hDEADBEEF, 4'b0100, 1'b0, 4'b0100, 8'hAD, 1'b1};
    vecs[7] = '{4'b1111, 32'h80FF0102, 4'b1000, 1'b0, 4'b1000, 8'h80, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_din", tx_din, 0);
    chk("rst_odd", tx_odd, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_active", active, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single transfers, pointer walk and wrap
    for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

    // all four held: served in index order from pointer 0
    wait_idle();
    req_din = 32'h44332211;
    req_odd = 4'b0101;
    req     = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      int n = 0;
      while (grant == 4'd0 && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      chk("all4_grant", grant, 32'(1 << i));
      finish_xfer(4'(1 << i), {req_odd[i], req_din[8*i +: 8]});
    end

    // timeout: busy never rises
    wait_idle();
    busy_mode = 1;
    req_din   = 32'h000000F0;
    req_odd   = 4'b0000;
    req       = 4'b0001;
    @(negedge clk);
    chk("to_grant", grant, 4'b0001);
    begin
      int cnt = 0;
      int g = 0;
      while (tx_send && cnt < 200) begin
        cnt++;
        @(negedge clk);
      end
      chk("to_send_len", cnt, BT);
      chk("to_ack", ack, 4'b0001);
      chk("to_terr", timeout_err, 1);
      chk("to_grant_clr", grant, 0);
      req = '0;
      while (active && g < 100) begin
        g++;
        @(negedge clk);
        if (g == 1) chk("to_terr_pulse", timeout_err, 0);
      end
      chk("to_gap_len", g, GAPC);
    end
    busy_mode = 0;

    // pointer now 1: requester 3 beats 0
    vw = '{4'b1001, 32'h6B000017, 4'b1000, 1'b0, 4'b1000, 8'h6B, 1'b1};
    do_xfer(vw);

    // reset during WAIT_DONE with the frame still in flight
    wait_idle();
    req_din = 32'h00009C00;
    req_odd = 4'b0010;
    req     = 4'b0010;
    begin
      int n = 0;
      int viol = 0;
      while (!(grant != 4'd0 && !tx_send && tx_busy) && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      chk("rf_wait_done", grant, 4'b0010);
      busy_mode = 2;
      #2 rst_n = 1'b0;
      #1;
      chk("rf_ack", ack, 0);
      chk("rf_grant", grant, 0);
      chk("rf_send", tx_send, 0);
      chk("rf_din", tx_din, 0);
      chk("rf_odd", tx_odd, 0);
      chk("rf_terr", timeout_err, 0);
      chk("rf_active", active, 0);
      chk_frame("rf_frame", 9'h19C);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (grant != 4'd0 || tx_send || active) viol++;
      end
      chk("rf_hold_off", viol, 0);
      busy_mode = 0;
      n = 0;
      while (grant == 4'd0 && n < BOUND) begin
        @(negedge clk);
        n++;
      end
      chk("rf_regrant", grant, 4'b0010);
      chk("rf_regrant_din", tx_din, 8'h9C);
      finish_xfer(4'b0010, 9'h19C);
      req = '0;
    end

    // randomized traffic against the round-robin reference
    wait_idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int ptr = 0;
      int cur = -1;
      int done = 0;
      int cyc = 0;
      int last_fall = -1000;
      int w;
      logic busy_prev = 1'b0;
      logic [8:0] exp_frame = '0;
      logic [3:0] acked;
      while (done < 40 && cyc < 8000) begin
        @(negedge clk);
        cyc++;
        acked = '0;
        if (busy_prev && !tx_busy) last_fall = cyc;
        busy_prev = tx_busy;
        if (ack != 4'd0) begin
          chk("rnd_ack", ack, (cur >= 0) ? 32'(1 << cur) : 32'd0);
          chk("rnd_terr", timeout_err, 0);
          chk_frame("rnd_frame", exp_frame);
          if (cur >= 0) begin
            ptr        = (cur + 1) % NREQ;
            req[cur]   = 1'b0;
            acked[cur] = 1'b1;
          end
          cur = -1;
          done++;
        end else if (grant != 4'd0) begin
          if (cur < 0) begin
            w = rr_ref(ptr, req);
            chk("rnd_grant", grant, (w >= 0) ? 32'(1 << w) : 32'd0);
            if (w >= 0) begin
              exp_frame = {req_odd[w], req_din[8*w +: 8]};
              chk("rnd_din", {tx_odd, tx_din}, exp_frame);
              chk("rnd_gap", 32'(cyc - last_fall >= GAPC + 2), 1);
              cur = w;
            end
          end else begin
            chk("rnd_hold", {grant, tx_odd, tx_din}, {4'(1 << cur), exp_frame});
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          if (cur == i) begin
            req_din[8*i +: 8] = 8'($urandom);
          end else if (!req[i] && !acked[i] && $urandom_range(0, 7) == 0) begin
            req[i]            = 1'b1;
            req_din[8*i +: 8] = 8'($urandom);
            req_odd[i]        = 1'($urandom);
          end
        end
      end
      chk("rnd_done", done, 40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
